// File: rtl/aes_block_uart_sender.sv
// Serializes one AES result block into NUM_BYTES bytes for a UART transmitter.
// One tx_drive pulse per byte, optional inter-byte gap, watchdog abort on a stalled UART.
module aes_block_uart_sender #(
  parameter int unsigned NUM_BYTES    = 16,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned TIMEOUT_CLKS = 10000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   blk_valid_i,
  input  logic [8*NUM_BYTES-1:0] blk_data_i,
  output logic                   blk_ready_o,
  output logic                   tx_drive_o,
  output logic [7:0]             tx_byte_in_o,
  input  logic                   tx_active_i,
  input  logic                   tx_done_i,
  output logic                   busy_o,
  output logic                   blk_sent_o,
  output logic                   tx_timeout_o
);

  localparam int unsigned DATA_W = 8 * NUM_BYTES;
  localparam int unsigned IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned WD_W   = 32;
  localparam int unsigned GAP_W  = 32;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP,
    FINISH,
    ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic       blk_ready_q, blk_ready_d;
  logic       tx_drive_q, tx_drive_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       busy_q, busy_d;
  logic       blk_sent_q, blk_sent_d;
  logic       tx_timeout_q, tx_timeout_d;

  // UART busy flag is observed only; it never gates the sequencing.
  logic unused_tx_active;
  assign unused_tx_active = tx_active_i;

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] data,
                                         input logic [IDX_W-1:0]  idx);
    logic [DATA_W-1:0] shifted;
    if (MSB_FIRST) shifted = data >> (8 * (NUM_BYTES - 1 - 32'(idx)));
    else           shifted = data >> (8 * 32'(idx));
    return shifted[7:0];
  endfunction

  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    buf_d   = buf_q;

    unique case (state_q)
      IDLE: begin
        if (blk_valid_i && blk_ready_q) begin
          buf_d   = blk_data_i;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        wd_d    = wd_inc;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (GAP_CLKS > 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              state_d = SEND;
            end
          end
        end else if ((TIMEOUT_CLKS != 0) && (wd_q >= WD_LIMIT)) begin
          state_d = ABORT;
        end else begin
          wd_d = wd_inc;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = SEND;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      FINISH: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      ABORT: begin
        idx_d   = '0;
        buf_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The watchdog measures from the drive cycle itself.
    if (state_d == SEND) wd_d = '0;

    blk_ready_d  = (state_d == IDLE);
    tx_drive_d   = (state_d == SEND);
    busy_d       = (state_d != IDLE);
    blk_sent_d   = (state_d == FINISH);
    tx_timeout_d = (state_d == ABORT);
    tx_byte_d    = (state_d == SEND) ? byte_at(buf_d, idx_d) : tx_byte_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      wd_q         <= '0;
      buf_q        <= '0;
      blk_ready_q  <= 1'b0;
      tx_drive_q   <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      blk_sent_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      buf_q        <= buf_d;
      blk_ready_q  <= blk_ready_d;
      tx_drive_q   <= tx_drive_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      blk_sent_q   <= blk_sent_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign blk_ready_o  = blk_ready_q;
  assign tx_drive_o   = tx_drive_q;
  assign tx_byte_in_o = tx_byte_q;
  assign busy_o       = busy_q;
  assign blk_sent_o   = blk_sent_q;
  assign tx_timeout_o = tx_timeout_q;

endmodule
